// File: rtl/cpu_pkg.sv
// Shared CPU constants: field widths and opcode encodings.
package cpu_pkg;

  localparam int unsigned IMM_WIDTH = 8;
  localparam int unsigned I_WIDTH   = 16;
  localparam int unsigned OP_WIDTH  = 4;

  localparam logic [OP_WIDTH-1:0] P_NOP = 4'hE;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: ROM port, decoder port and run/stall control.
interface fetch_if #(
  parameter int unsigned PC_WIDTH  = cpu_pkg::IMM_WIDTH,
  parameter int unsigned I_WIDTH   = cpu_pkg::I_WIDTH,
  parameter int unsigned CNT_WIDTH = 16
);

  logic                 run;
  logic                 stall;
  logic                 branch_en;
  logic [PC_WIDTH-1:0]  branch_target;
  logic [PC_WIDTH-1:0]  rom_addr;
  logic                 rom_en;
  logic [I_WIDTH-1:0]   rom_data;
  logic [I_WIDTH-1:0]   instruction;
  logic                 instr_valid;
  logic [PC_WIDTH-1:0]  pc;
  logic [CNT_WIDTH-1:0] icount;

  // Fetch unit side
  modport master (
    input  run, stall, branch_en, branch_target, rom_data,
    output rom_addr, rom_en, instruction, instr_valid, pc, icount
  );

  // Environment side: ROM, decoder and control
  modport slave (
    output run, stall, branch_en, branch_target, rom_data,
    input  rom_addr, rom_en, instruction, instr_valid, pc, icount
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a sync-read ROM, presents one
// instruction per cycle, redirects on taken branches with a one-cycle bubble.
module fetch_unit #(
  parameter int unsigned PC_WIDTH  = cpu_pkg::IMM_WIDTH,
  parameter int unsigned I_WIDTH   = cpu_pkg::I_WIDTH,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic    clk,
  input  logic    nReset,
  fetch_if.master bus
);

  import cpu_pkg::*;

  localparam logic [I_WIDTH-1:0] NOP_WORD = {P_NOP, {(I_WIDTH-OP_WIDTH){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PC_WIDTH-1:0]  f_q, f_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] icount_q, icount_d;
  logic                 rom_en_c;

  // State and fetch registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      f_q      <= '0;
      pc_q     <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      f_q      <= f_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
    end
  end

  // Next-state, fetch address and ROM enable
  always_comb begin
    state_d  = state_q;
    f_d      = f_q;
    pc_d     = pc_q;
    icount_d = icount_q;
    rom_en_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.run) begin
          rom_en_c = 1'b1;
          pc_d     = f_q;
          f_d      = f_q + PC_WIDTH'(1);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          icount_d = icount_q + CNT_WIDTH'(1);
          if (bus.branch_en) begin
            f_d     = bus.branch_target;
            state_d = bus.run ? FLUSH : IDLE;
          end else if (!bus.run) begin
            state_d = IDLE;
          end else begin
            rom_en_c = 1'b1;
            pc_d     = f_q;
            f_d      = f_q + PC_WIDTH'(1);
          end
        end
      end
      FLUSH: begin
        // ROM output is stale here; stall and branch_en have no meaning.
        if (bus.run) begin
          rom_en_c = 1'b1;
          pc_d     = f_q;
          f_d      = f_q + PC_WIDTH'(1);
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output mapping; the ROM is kept disabled while reset is asserted
  assign bus.rom_addr    = f_q;
  assign bus.rom_en      = rom_en_c & nReset;
  assign bus.pc          = pc_q;
  assign bus.icount      = icount_q;
  assign bus.instr_valid = (state_q == RUN);
  assign bus.instruction = (state_q == RUN) ? bus.rom_data : NOP_WORD;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the decoder. It owns the program counter, drives a synchronous-read program ROM, and presents one instruction per cycle to the decoder. It redirects fetch when the decoder reports a taken branch, and supports run/stall control plus a retired-instruction counter. Squashed or idle slots are presented as NOP so the decoder never acts on stale ROM data.

## Interface
Parameters:
- PC_WIDTH, default cpu_pkg::IMM_WIDTH: program counter and branch target width.
- I_WIDTH, default cpu_pkg::I_WIDTH: instruction word width.
- CNT_WIDTH, default 16: retired-instruction counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = fetch and issue, 0 = pause after the current instruction.
- stall  in  1  downstream hold; freezes the presented instruction and all fetch state while in RUN.
- branch_en  in  1  from decoder; taken branch for the instruction presented this cycle.
- branch_target  in  PC_WIDTH  from decoder; redirect address.
- rom_addr  out  PC_WIDTH  ROM address; equals the fetch register F.
- rom_en  out  1  ROM read enable; ROM latches rom_addr at the edge when 1 and holds its output when 0.
- rom_data  in  I_WIDTH  ROM output word, valid in the cycle after the read edge.
- instruction  out  I_WIDTH  to decoder; rom_data when instr_valid = 1, otherwise NOP_WORD = {P_NOP, zeros}.
- instr_valid  out  1  instruction is real and executes this cycle (when stall = 0).
- pc  out  PC_WIDTH  address of the presented instruction.
- icount  out  CNT_WIDTH  retired-instruction count.

## Operation
- Registers:
  - F: next fetch address.
  - pc_q: address of the word currently on rom_data.
  - state: IDLE, RUN or FLUSH.
  - icount.
- Outputs:
  - rom_addr = F.
  - pc = pc_q.
  - instr_valid = (state == RUN).
  - instruction = instr_valid ? rom_data : NOP_WORD.
- IDLE:
  - If run = 0: rom_en = 0; hold.
  - If run = 1: rom_en = 1; pc_q <= F; F <= F+1; go to RUN.
- RUN, stall = 1: rom_en = 0; hold all state; branch_en ignored; icount unchanged. Stall takes priority over run = 0.
- RUN, stall = 0: the instruction retires, icount <= icount+1. Then, in priority order:
  - branch_en = 1: rom_en = 0; F <= branch_target; go to FLUSH if run = 1, else IDLE.
  - run = 0: rom_en = 0; F holds (already pc_q+1); go to IDLE.
  - otherwise: rom_en = 1; pc_q <= F; F <= F+1; stay in RUN.
- FLUSH (one bubble; ROM output is stale and masked):
  - stall and branch_en are ignored.
  - If run = 1: rom_en = 1; pc_q <= F; F <= F+1; go to RUN.
  - If run = 0: rom_en = 0; go to IDLE, with F still holding the target.
- Arithmetic:
  - F increments modulo 2^PC_WIDTH, so the maximum address wraps to 0.
  - icount wraps modulo 2^CNT_WIDTH.
- PCincr from the decoder is not consumed. Fetch acts on branch_en only.

## Timing
- Reset (asynchronous, nReset = 0):
  - state = IDLE; F = 0; pc_q = 0; icount = 0.
  - Outputs: rom_addr = 0, rom_en = 0, instr_valid = 0, instruction = NOP_WORD, pc = 0, icount = 0.
  - Reset mid-operation aborts any pending redirect. Fetch restarts from 0.
- Start-up latency: run rises in cycle t (IDLE) → the instruction at F is presented with instr_valid = 1 in cycle t+1.
- Sequential code: one instruction per cycle with no gaps.
- Taken branch: decided in cycle t → FLUSH bubble in t+1 (instr_valid = 0) → the target instruction is presented in t+2. Branch penalty is 1 cycle.
- Branch to self (e.g. SW8 polling loop): valid every other cycle, pc constant.
- Stall: the presented instruction, pc and rom_data are held for the full stall duration and re-presented unchanged when stall falls.
- rom_en is combinational from state, run, stall and branch_en. It has no registered delay.

## Test plan
- Reset then run = 1, ROM words 0..3 sequential: instr_valid rises one cycle after run; pc shows 0, 1, 2, 3 on consecutive cycles; icount = 4 after 4 valid cycles.
- Instruction at pc 2 asserts branch_en with branch_target = 0x10: cycle after is NOP with instr_valid = 0; the next cycle shows pc = 0x10 with rom_data = mem[0x10]; mem[3] is never presented.
- Stall for 3 cycles while pc = 5: instruction, pc = 5 and icount are frozen and rom_en = 0 throughout; pc = 6 follows on the first unstalled cycle after pc 5 retires.
- run falls while pc = 7 is presented: 7 retires and the block enters IDLE with rom_addr = 8; run rises later and pc = 8 is presented one cycle afterwards, with no instruction skipped or repeated.
- PC_WIDTH = 8, straight-line code reaching pc = 0xFF: the next presented pc = 0x00; set icount to 0xFFFF and retire once → icount = 0x0000.
- nReset pulsed low during FLUSH after a branch to 0x20: all outputs return to reset values immediately; after release and run = 1, fetch starts at pc = 0, not 0x20.
